bcd_countdown_timer: RTL and testbench

Parametrised BCD countdown timer for the irrigation controller. It is generalised to NUM_FIELDS two-digit fields (MM:SS by default, HH:MM:SS with 3). It adds start, pause and resume, a load strobe, an auto-reload mode and a done/expired handshake. It has an internal one-second prescaler and a built-in multiplexed 7-segment scan, so the top level only connects pins.

---
 rtl/timer_pkg.sv | 50 +++++
 rtl/timer_bcd_field.sv | 44 ++++
 rtl/bcd_countdown_timer.sv | 201 ++++++++++++++++++++
 tb/tb_bcd_countdown_timer.sv | 168 ++++++++++++++++
 4 files changed

// File: rtl/timer_pkg.sv
// Shared types and helpers for the BCD countdown timer: FSM states,
// BCD digit width, 7-segment codes and the digit clamp.
package timer_pkg;

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      RUN     = 2'd1,
      PAUSED  = 2'd2,
      EXPIRED = 2'd3
   } state_t;

   localparam int BCD_W = 4;

   // Segment order is {g,f,e,d,c,b,a}, active-high.
   localparam logic [6:0] SEG_0     = 7'h3F;
   localparam logic [6:0] SEG_1     = 7'h06;
   localparam logic [6:0] SEG_2     = 7'h5B;
   localparam logic [6:0] SEG_3     = 7'h4F;
   localparam logic [6:0] SEG_4     = 7'h66;
   localparam logic [6:0] SEG_5     = 7'h6D;
   localparam logic [6:0] SEG_6     = 7'h7D;
   localparam logic [6:0] SEG_7     = 7'h07;
   localparam logic [6:0] SEG_8     = 7'h7F;
   localparam logic [6:0] SEG_9     = 7'h6F;
   localparam logic [6:0] SEG_BLANK = 7'h00;

   function automatic logic [BCD_W-1:0] clamp_digit(input logic [BCD_W-1:0] d,
                                                    input logic [BCD_W-1:0] max);
      return (d > max) ? max : d;
   endfunction

   function automatic logic [6:0] seg_code(input logic [BCD_W-1:0] d);
      logic [6:0] code;
      case (d)
         4'd0:    code = SEG_0;
         4'd1:    code = SEG_1;
         4'd2:    code = SEG_2;
         4'd3:    code = SEG_3;
         4'd4:    code = SEG_4;
         4'd5:    code = SEG_5;
         4'd6:    code = SEG_6;
         4'd7:    code = SEG_7;
         4'd8:    code = SEG_8;
         4'd9:    code = SEG_9;
         default: code = SEG_BLANK;
      endcase
      return code;
   endfunction

endpackage

// File: rtl/timer_bcd_field.sv
// One two-digit BCD field (units 0-9, tens 0-TENS_MAX) with load and
// borrow-chained decrement.
module timer_bcd_field
   import timer_pkg::*;
#(
   parameter logic [3:0] TENS_MAX = 4'd5
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic                 load,
   input  logic [2*BCD_W-1:0]   load_value,
   input  logic                 dec,
   input  logic                 borrow_in,
   output logic [2*BCD_W-1:0]   value,
   output logic                 borrow_out,
   output logic                 is_zero
);

   logic [BCD_W-1:0] units_r;
   logic [BCD_W-1:0] tens_r;

   assign is_zero    = (units_r == 4'd0) && (tens_r == 4'd0);
   assign borrow_out = borrow_in && is_zero;
   assign value      = {tens_r, units_r};

   // Digit registers: load wins over a decrement step.
   always_ff @(posedge clk) begin
      if (reset) begin
         units_r <= 4'd0;
         tens_r  <= 4'd0;
      end else if (load) begin
         units_r <= load_value[BCD_W-1:0];
         tens_r  <= load_value[2*BCD_W-1:BCD_W];
      end else if (dec && borrow_in) begin
         if (units_r == 4'd0) begin
            units_r <= 4'd9;
            tens_r  <= (tens_r == 4'd0) ? TENS_MAX : (tens_r - 4'd1);
         end else begin
            units_r <= units_r - 4'd1;
         end
      end
   end

endmodule

// File: rtl/bcd_countdown_timer.sv
// BCD countdown timer: NUM_FIELDS two-digit fields, run/pause/expire FSM,
// one-step prescaler, auto-reload and a multiplexed 7-segment scan.
module bcd_countdown_timer
   import timer_pkg::*;
#(
   parameter int NUM_FIELDS     = 2,
   parameter int TICK_DIV       = 50_000_000,
   parameter int SCAN_DIV       = 50_000,
   parameter int TOP_TENS_MAX   = 5,
   parameter int SEG_ACTIVE_LOW = 1
) (
   input  logic                    clk,
   input  logic                    reset,
   input  logic                    load,
   input  logic [8*NUM_FIELDS-1:0] preset,
   input  logic                    start,
   input  logic                    pause,
   input  logic                    auto_reload,
   output logic [8*NUM_FIELDS-1:0] count,
   output logic                    running,
   output logic                    done,
   output logic                    expired,
   output logic [6:0]              seg,
   output logic [2*NUM_FIELDS-1:0] digit_en,
   output logic                    dp
);

   localparam int D  = 2 * NUM_FIELDS;
   localparam int W  = 8 * NUM_FIELDS;
   localparam int PW = $clog2(TICK_DIV);
   localparam int SW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
   localparam int IW = $clog2(D);
   localparam logic [PW-1:0]    PRESC_LAST = PW'(TICK_DIV - 1);
   localparam logic [SW-1:0]    SCAN_LAST  = SW'(SCAN_DIV - 1);
   localparam logic [IW-1:0]    IDX_LAST   = IW'(D - 1);
   localparam logic [BCD_W-1:0] TOP_TENS   = BCD_W'(TOP_TENS_MAX);
   localparam logic [6:0]       SEG_MASK   = (SEG_ACTIVE_LOW != 0) ? 7'h7F : 7'h00;

   state_t          state_r, state_next_s;
   logic [PW-1:0]   presc_r, presc_next_s;
   logic [W-1:0]    reload_r;
   logic [W-1:0]    preset_clamped_s;
   logic [W-1:0]    field_load_value_s;
   logic [W-1:0]    count_s;
   logic            field_load_s;
   logic            reload_now_s;
   logic            tick_s;
   logic            dec_s;
   logic            done_next_s;
   logic            count_zero_s;
   logic            done_r, running_r, expired_r;
   logic [NUM_FIELDS:0]   borrow_s;
   logic [NUM_FIELDS-1:0] zero_s;

   logic [SW-1:0]    scan_r, scan_next_s;
   logic [IW-1:0]    idx_r, idx_next_s;
   logic [BCD_W-1:0] digit_s;
   logic [6:0]       seg_drive_s;
   logic [6:0]       seg_r;
   logic [D-1:0]     digit_en_r;
   logic             dp_r;

   // Clamp the preset digit by digit; only the top field may exceed tens=5.
   always_comb begin
      preset_clamped_s = '0;
      for (int f = 0; f < NUM_FIELDS; f++) begin
         preset_clamped_s[8*f +: BCD_W] = clamp_digit(preset[8*f +: BCD_W], 4'd9);
         preset_clamped_s[8*f+BCD_W +: BCD_W] =
            clamp_digit(preset[8*f+BCD_W +: BCD_W], (f == NUM_FIELDS-1) ? TOP_TENS : 4'd5);
      end
   end

   assign field_load_s       = load || reload_now_s;
   assign field_load_value_s = load ? preset_clamped_s : reload_r;
   assign borrow_s[0]        = 1'b1;
   assign count_zero_s       = &zero_s;
   assign dec_s              = tick_s && !borrow_s[NUM_FIELDS];

   for (genvar f = 0; f < NUM_FIELDS; f++) begin : g_field
      timer_bcd_field #(
         .TENS_MAX((f == NUM_FIELDS-1) ? TOP_TENS : 4'd5)
      ) u_field (
         .clk       (clk),
         .reset     (reset),
         .load      (field_load_s),
         .load_value(field_load_value_s[8*f +: 8]),
         .dec       (dec_s),
         .borrow_in (borrow_s[f]),
         .value     (count_s[8*f +: 8]),
         .borrow_out(borrow_s[f+1]),
         .is_zero   (zero_s[f])
      );
   end

   // Next state, prescaler step and expiry/reload decisions.
   always_comb begin
      state_next_s = state_r;
      presc_next_s = presc_r;
      tick_s       = 1'b0;
      reload_now_s = 1'b0;
      done_next_s  = 1'b0;
      if (load) begin
         state_next_s = IDLE;
         presc_next_s = '0;
      end else begin
         case (state_r)
            IDLE: begin
               if (start && !count_zero_s) state_next_s = RUN;
               else                        state_next_s = IDLE;
            end
            RUN: begin
               if (count_zero_s) begin
                  // Zero was reached by the previous step: pulse done, then reload or stop.
                  done_next_s = 1'b1;
                  if (auto_reload && (reload_r != '0)) begin
                     reload_now_s = 1'b1;
                     presc_next_s = '0;
                  end else begin
                     state_next_s = EXPIRED;
                  end
               end else begin
                  if (presc_r == PRESC_LAST) begin
                     presc_next_s = '0;
                     tick_s       = 1'b1;
                  end else begin
                     presc_next_s = presc_r + PW'(1);
                  end
                  if (pause) state_next_s = PAUSED;
                  else       state_next_s = RUN;
               end
            end
            PAUSED: begin
               if (start && !pause) state_next_s = RUN;
               else                 state_next_s = PAUSED;
            end
            EXPIRED: state_next_s = EXPIRED;
            default: state_next_s = IDLE;
         endcase
      end
   end

   // FSM, prescaler, reload register and status outputs.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_r   <= IDLE;
         presc_r   <= '0;
         reload_r  <= '0;
         done_r    <= 1'b0;
         running_r <= 1'b0;
         expired_r <= 1'b0;
      end else begin
         state_r   <= state_next_s;
         presc_r   <= presc_next_s;
         done_r    <= done_next_s;
         running_r <= (state_next_s == RUN);
         expired_r <= (state_next_s == EXPIRED);
         if (load) reload_r <= preset_clamped_s;
         else      reload_r <= reload_r;
      end
   end

   // Scan divider and digit index selection.
   always_comb begin
      scan_next_s = scan_r;
      idx_next_s  = idx_r;
      if (scan_r == SCAN_LAST) begin
         scan_next_s = '0;
         idx_next_s  = (idx_r == IDX_LAST) ? '0 : (idx_r + IW'(1));
      end else begin
         scan_next_s = scan_r + SW'(1);
      end
      digit_s     = count_s[BCD_W*int'(idx_next_s) +: BCD_W];
      seg_drive_s = seg_code(digit_s) ^ SEG_MASK;
   end

   // Registered display drive.
   always_ff @(posedge clk) begin
      if (reset) begin
         scan_r     <= '0;
         idx_r      <= '0;
         digit_en_r <= D'(1);
         seg_r      <= SEG_0 ^ SEG_MASK;
         dp_r       <= 1'b0;
      end else begin
         scan_r     <= scan_next_s;
         idx_r      <= idx_next_s;
         digit_en_r <= D'(1) << idx_next_s;
         seg_r      <= seg_drive_s;
         dp_r       <= (idx_next_s[0] == 1'b0) && (int'(idx_next_s) >= 2);
      end
   end

   assign count    = count_s;
   assign running  = running_r;
   assign done     = done_r;
   assign expired  = expired_r;
   assign seg      = seg_r;
   assign digit_en = digit_en_r;
   assign dp       = dp_r;

endmodule

// File: tb/tb_bcd_countdown_timer.sv
// Directed self-checking bench for bcd_countdown_timer
// (NUM_FIELDS=2, TICK_DIV=4, SCAN_DIV=2).
module tb_bcd_countdown_timer;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic        load = 1'b0;
   logic [15:0] preset = 16'h0000;
   logic        start = 1'b0;
   logic        pause = 1'b0;
   logic        auto_reload = 1'b0;
   logic [15:0] count;
   logic        running, done, expired, dp;
   logic [6:0]  seg;
   logic [3:0]  digit_en;

   int total = 0;
   int bad = 0;

   bcd_countdown_timer #(
      .NUM_FIELDS(2), .TICK_DIV(4), .SCAN_DIV(2), .TOP_TENS_MAX(5), .SEG_ACTIVE_LOW(1)
   ) dut (
      .clk(clk), .reset(reset), .load(load), .preset(preset), .start(start),
      .pause(pause), .auto_reload(auto_reload), .count(count), .running(running),
      .done(done), .expired(expired), .seg(seg), .digit_en(digit_en), .dp(dp)
   );

   always #5 clk = ~clk;

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic do_load(input logic [15:0] value);
      preset = value;
      load = 1'b1;
      step();
      load = 1'b0;
   endtask

   task automatic do_start();
      start = 1'b1;
      step();
      start = 1'b0;
   endtask

   task automatic test_reset();
      logic [3:0] exp_en;
      reset = 1'b1;
      repeat (3) step();
      total++; if (count !== 16'h0000) begin bad++; $display("FAIL reset_count got=%h exp=%h", count, 16'h0000); end
      total++; if (digit_en !== 4'b0001) begin bad++; $display("FAIL reset_digit_en got=%b exp=%b", digit_en, 4'b0001); end
      total++; if (running !== 1'b0) begin bad++; $display("FAIL reset_running got=%b exp=0", running); end
      total++; if (done !== 1'b0) begin bad++; $display("FAIL reset_done got=%b exp=0", done); end
      total++; if (expired !== 1'b0) begin bad++; $display("FAIL reset_expired got=%b exp=0", expired); end
      total++; if (dp !== 1'b0) begin bad++; $display("FAIL reset_dp got=%b exp=0", dp); end
      total++; if (seg !== 7'h40) begin bad++; $display("FAIL reset_seg got=%h exp=%h", seg, 7'h40); end
      reset = 1'b0;
      for (int k = 1; k <= 9; k++) begin
         step();
         exp_en = 4'b0001 << ((k / 2) % 4);
         total++; if (digit_en !== exp_en) begin bad++; $display("FAIL scan_digit_en cyc=%0d got=%b exp=%b", k, digit_en, exp_en); end
         total++; if (dp !== (exp_en == 4'b0100)) begin bad++; $display("FAIL scan_dp cyc=%0d got=%b exp=%b", k, dp, exp_en == 4'b0100); end
         total++; if (seg !== 7'h40) begin bad++; $display("FAIL scan_seg cyc=%0d got=%h exp=%h", k, seg, 7'h40); end
      end
   endtask

   task automatic test_countdown();
      do_load(16'h0100);
      total++; if (count !== 16'h0100) begin bad++; $display("FAIL cd_load got=%h exp=%h", count, 16'h0100); end
      total++; if (running !== 1'b0) begin bad++; $display("FAIL cd_idle_running got=%b exp=0", running); end
      do_start();
      total++; if (running !== 1'b1) begin bad++; $display("FAIL cd_running got=%b exp=1", running); end
      repeat (3) step();
      total++; if (count !== 16'h0100) begin bad++; $display("FAIL cd_before_tick got=%h exp=%h", count, 16'h0100); end
      step();
      total++; if (count !== 16'h0059) begin bad++; $display("FAIL cd_first_tick got=%h exp=%h", count, 16'h0059); end
      repeat (4) step();
      total++; if (count !== 16'h0058) begin bad++; $display("FAIL cd_second_tick got=%h exp=%h", count, 16'h0058); end
   endtask

   task automatic test_expire();
      do_load(16'h0002);
      do_start();
      repeat (7) step();
      total++; if (count !== 16'h0001) begin bad++; $display("FAIL exp_mid got=%h exp=%h", count, 16'h0001); end
      step();
      total++; if (count !== 16'h0000) begin bad++; $display("FAIL exp_zero got=%h exp=%h", count, 16'h0000); end
      total++; if (done !== 1'b0) begin bad++; $display("FAIL exp_done_early got=%b exp=0", done); end
      step();
      total++; if (done !== 1'b1) begin bad++; $display("FAIL exp_done got=%b exp=1", done); end
      total++; if (expired !== 1'b1) begin bad++; $display("FAIL exp_expired got=%b exp=1", expired); end
      total++; if (running !== 1'b0) begin bad++; $display("FAIL exp_running got=%b exp=0", running); end
      step();
      total++; if (done !== 1'b0) begin bad++; $display("FAIL exp_done_once got=%b exp=0", done); end
      total++; if (expired !== 1'b1) begin bad++; $display("FAIL exp_expired_hold got=%b exp=1", expired); end
      do_start();
      step();
      total++; if (count !== 16'h0000) begin bad++; $display("FAIL exp_start_count got=%h exp=%h", count, 16'h0000); end
      total++; if (running !== 1'b0) begin bad++; $display("FAIL exp_start_running got=%b exp=0", running); end
      total++; if (expired !== 1'b1) begin bad++; $display("FAIL exp_start_expired got=%b exp=1", expired); end
   endtask

   task automatic test_pause();
      do_load(16'h0030);
      do_start();
      step();
      pause = 1'b1;
      step();
      pause = 1'b0;
      total++; if (running !== 1'b0) begin bad++; $display("FAIL pause_running got=%b exp=0", running); end
      repeat (10) step();
      total++; if (count !== 16'h0030) begin bad++; $display("FAIL pause_hold got=%h exp=%h", count, 16'h0030); end
      do_start();
      total++; if (running !== 1'b1) begin bad++; $display("FAIL resume_running got=%b exp=1", running); end
      step();
      total++; if (count !== 16'h0030) begin bad++; $display("FAIL resume_early got=%h exp=%h", count, 16'h0030); end
      step();
      total++; if (count !== 16'h0029) begin bad++; $display("FAIL resume_tick got=%h exp=%h", count, 16'h0029); end
   endtask

   task automatic test_auto_reload();
      logic [15:0] exp_count;
      auto_reload = 1'b1;
      do_load(16'h0001);
      do_start();
      for (int k = 1; k <= 15; k++) begin
         step();
         exp_count = ((k % 5) == 4) ? 16'h0000 : 16'h0001;
         total++; if (done !== ((k % 5) == 0)) begin bad++; $display("FAIL ar_done cyc=%0d got=%b exp=%b", k, done, (k % 5) == 0); end
         total++; if (count !== exp_count) begin bad++; $display("FAIL ar_count cyc=%0d got=%h exp=%h", k, count, exp_count); end
         total++; if (expired !== 1'b0) begin bad++; $display("FAIL ar_expired cyc=%0d got=%b exp=0", k, expired); end
         total++; if (running !== 1'b1) begin bad++; $display("FAIL ar_running cyc=%0d got=%b exp=1", k, running); end
      end
      auto_reload = 1'b0;
   endtask

   task automatic test_clamp_reset();
      do_load(16'h0A7C);
      total++; if (count !== 16'h0959) begin bad++; $display("FAIL clamp got=%h exp=%h", count, 16'h0959); end
      do_start();
      repeat (5) step();
      total++; if (count !== 16'h0958) begin bad++; $display("FAIL clamp_run got=%h exp=%h", count, 16'h0958); end
      reset = 1'b1;
      step();
      reset = 1'b0;
      total++; if (count !== 16'h0000) begin bad++; $display("FAIL rst_run_count got=%h exp=%h", count, 16'h0000); end
      total++; if (running !== 1'b0) begin bad++; $display("FAIL rst_run_running got=%b exp=0", running); end
      for (int k = 0; k < 6; k++) begin
         total++; if (done !== 1'b0) begin bad++; $display("FAIL rst_run_done cyc=%0d got=%b exp=0", k, done); end
         step();
      end
      total++; if (count !== 16'h0000) begin bad++; $display("FAIL rst_run_idle got=%h exp=%h", count, 16'h0000); end
   endtask

   initial begin
      test_reset();
      test_countdown();
      test_expire();
      test_pause();
      test_auto_reload();
      test_clamp_reset();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
